// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch-in-ID hazard detection.
// Define ID_EX_PERF_EN to build the stall-cycle counter behind stall_count.
module id_ex_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          ID_valid,
  input  logic [4:0]    ID_rs,
  input  logic [4:0]    ID_rt,
  input  logic [4:0]    ID_RW,
  input  logic          ID_regwe,
  input  logic          ID_ramwe,
  input  logic          ID_memtoreg,
  input  logic          ID_branch,
  input  logic [3:0]    ID_aluop,
  input  logic [DW-1:0] ID_R1,
  input  logic [DW-1:0] ID_R2,
  input  logic [DW-1:0] ID_imm,
  input  logic [DW-1:0] ID_pc,
  input  logic [4:0]    MEM_RW,
  input  logic          MEM_memtoreg,
  output logic          EX_valid,
  output logic [4:0]    EX_rs,
  output logic [4:0]    EX_rt,
  output logic [4:0]    EX_RW,
  output logic          EX_regwe,
  output logic          EX_ramwe,
  output logic          EX_memtoreg,
  output logic [3:0]    EX_aluop,
  output logic [DW-1:0] EX_R1,
  output logic [DW-1:0] EX_R2,
  output logic [DW-1:0] EX_imm,
  output logic [DW-1:0] EX_pc,
  output logic          stall,
  output logic [31:0]   stall_count
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rw;
    logic          regwe;
    logic          ramwe;
    logic          memtoreg;
    logic [3:0]    aluop;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic ex_match, mem_match, hazard;

  // $0 is never a real dependency, so a zero destination never matches.
  always_comb begin
    ex_match  = (ex_q.rw != 5'd0) && ((ex_q.rw == ID_rs) || (ex_q.rw == ID_rt));
    mem_match = (MEM_RW != 5'd0) && ((MEM_RW == ID_rs) || (MEM_RW == ID_rt));
    hazard    = ID_valid &&
                ((ex_q.memtoreg && ex_q.regwe && ex_match) ||
                 (ID_branch && ex_q.regwe && ex_match) ||
                 (ID_branch && MEM_memtoreg && mem_match));
    stall     = hazard && !flush && !hold;
  end

  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      if (flush || stall) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = ID_valid;
        ex_d.rs       = ID_rs;
        ex_d.rt       = ID_rt;
        ex_d.rw       = ID_RW;
        ex_d.regwe    = ID_regwe && ID_valid;
        ex_d.ramwe    = ID_ramwe && ID_valid;
        ex_d.memtoreg = ID_memtoreg && ID_valid;
        ex_d.aluop    = ID_aluop;
        ex_d.r1       = ID_R1;
        ex_d.r2       = ID_R2;
        ex_d.imm      = ID_imm;
        ex_d.pc       = ID_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign EX_valid    = ex_q.valid;
  assign EX_rs       = ex_q.rs;
  assign EX_rt       = ex_q.rt;
  assign EX_RW       = ex_q.rw;
  assign EX_regwe    = ex_q.regwe;
  assign EX_ramwe    = ex_q.ramwe;
  assign EX_memtoreg = ex_q.memtoreg;
  assign EX_aluop    = ex_q.aluop;
  assign EX_R1       = ex_q.r1;
  assign EX_R2       = ex_q.r2;
  assign EX_imm      = ex_q.imm;
  assign EX_pc       = ex_q.pc;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  // stall already excludes hold, so the count freezes with the pipeline.
  always_comb begin
    stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction vectors, expected
// stall/EX/counter values queued by the driver and checked by a monitor.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int OC_LOAD = 0;
  localparam int OC_BUB  = 1;
  localparam int OC_HOLD = 2;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rw;
    logic          regwe;
    logic          ramwe;
    logic          memtoreg;
    logic [3:0]    aluop;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
  } ex_t;

  typedef struct packed {
    logic        stall;
    ex_t         ex;
    logic [31:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0, flush = 1'b0;
  logic          ID_valid = 1'b0;
  logic [4:0]    ID_rs = '0, ID_rt = '0, ID_RW = '0;
  logic          ID_regwe = 1'b0, ID_ramwe = 1'b0, ID_memtoreg = 1'b0, ID_branch = 1'b0;
  logic [3:0]    ID_aluop = '0;
  logic [DW-1:0] ID_R1 = '0, ID_R2 = '0, ID_imm = '0, ID_pc = '0;
  logic [4:0]    MEM_RW = '0;
  logic          MEM_memtoreg = 1'b0;
  logic          EX_valid, EX_regwe, EX_ramwe, EX_memtoreg, stall;
  logic [4:0]    EX_rs, EX_rt, EX_RW;
  logic [3:0]    EX_aluop;
  logic [DW-1:0] EX_R1, EX_R2, EX_imm, EX_pc;
  logic [31:0]   stall_count;

  id_ex_stage #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_RW(ID_RW),
    .ID_regwe(ID_regwe), .ID_ramwe(ID_ramwe), .ID_memtoreg(ID_memtoreg),
    .ID_branch(ID_branch), .ID_aluop(ID_aluop),
    .ID_R1(ID_R1), .ID_R2(ID_R2), .ID_imm(ID_imm), .ID_pc(ID_pc),
    .MEM_RW(MEM_RW), .MEM_memtoreg(MEM_memtoreg),
    .EX_valid(EX_valid), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_RW(EX_RW),
    .EX_regwe(EX_regwe), .EX_ramwe(EX_ramwe), .EX_memtoreg(EX_memtoreg),
    .EX_aluop(EX_aluop), .EX_R1(EX_R1), .EX_R2(EX_R2), .EX_imm(EX_imm),
    .EX_pc(EX_pc), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  ex_t         prev_ex = '0;
  logic [31:0] exp_cnt = '0;
  int          n_checks = 0, n_pass = 0, idx = 0;

  function automatic ex_t act_ex();
    return {EX_valid, EX_rs, EX_rt, EX_RW, EX_regwe, EX_ramwe, EX_memtoreg,
            EX_aluop, EX_R1, EX_R2, EX_imm, EX_pc};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: stall sampled mid-cycle before the edge, EX state just after it.
  initial begin
    logic s_stall;
    exp_t e;
    forever begin
      @(negedge clk);
      #3 s_stall = stall;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("stall[%0d]", idx), {159'd0, s_stall}, {159'd0, e.stall});
        check($sformatf("ex[%0d]", idx), {9'd0, act_ex()}, {9'd0, e.ex});
        check($sformatf("cnt[%0d]", idx), {128'd0, stall_count}, {128'd0, e.cnt});
      end
    end
  end

  task automatic issue(input logic v, input logic [4:0] rs, rt, rw,
                       input logic regwe, ramwe, mtr, br, input logic [3:0] aluop,
                       input logic hld, fl, input logic [4:0] mrw, input logic mmtr,
                       input logic xs, input int oc);
    exp_t e;
    @(negedge clk);
    #1;
    idx++;
    ID_valid = v; ID_rs = rs; ID_rt = rt; ID_RW = rw;
    ID_regwe = regwe; ID_ramwe = ramwe; ID_memtoreg = mtr; ID_branch = br;
    ID_aluop = aluop; hold = hld; flush = fl; MEM_RW = mrw; MEM_memtoreg = mmtr;
    ID_R1 = 32'hA100_0000 | idx;
    ID_R2 = 32'hB200_0000 | idx;
    ID_imm = 32'hC300_0000 | idx;
    ID_pc = 32'h0040_0000 + idx * 4;
    e.stall = xs;
    case (oc)
      OC_LOAD: e.ex = {v, rs, rt, rw, regwe & v, ramwe & v, mtr & v, aluop,
                       ID_R1, ID_R2, ID_imm, ID_pc};
      OC_BUB:  e.ex = '0;
      default: e.ex = prev_ex;
    endcase
    prev_ex = e.ex;
`ifdef ID_EX_PERF_EN
    if (xs) exp_cnt = exp_cnt + 32'd1;
`endif
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain", {128'd0, sb.size()}, 160'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_ex", {9'd0, act_ex()}, 160'd0);
    check("rst_stall", {159'd0, stall}, 160'd0);
    check("rst_cnt", {128'd0, stall_count}, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    //    v  rs  rt  rw regwe ramwe mtr br alu  hld fl mrw mmtr xs outcome
    issue(1, 1,  2,  3,  1,   0,    0,  0, 4'h2, 0, 0, 0,  0,   0, OC_LOAD); // add $3
    issue(1, 1,  0,  5,  1,   0,    1,  0, 4'h0, 0, 0, 3,  0,   0, OC_LOAD); // lw $5
    issue(1, 5,  2,  6,  1,   0,    0,  0, 4'h2, 0, 0, 3,  0,   1, OC_BUB);  // load-use
    issue(1, 5,  2,  6,  1,   0,    0,  0, 4'h2, 0, 0, 5,  1,   0, OC_LOAD);
    issue(1, 1,  0,  4,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD); // lw $4
    issue(1, 4,  0,  0,  0,   0,    0,  1, 4'h6, 0, 0, 6,  0,   1, OC_BUB);  // beq in EX hazard
    issue(1, 4,  0,  0,  0,   0,    0,  1, 4'h6, 0, 0, 4,  1,   1, OC_BUB);  // beq, load in MEM
    issue(1, 4,  0,  0,  0,   0,    0,  1, 4'h6, 0, 0, 0,  0,   0, OC_LOAD);
    issue(1, 1,  0,  0,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD); // lw $0
    issue(1, 0,  0,  7,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD); // $0 immunity
    issue(0, 7,  3,  9,  1,   1,    1,  0, 4'h3, 0, 0, 0,  0,   0, OC_LOAD); // invalid, gated
    issue(1, 1,  2,  8,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD); // lw $8
    issue(1, 8,  0, 10,  1,   0,    0,  0, 4'h2, 0, 1, 0,  0,   0, OC_BUB);  // hazard + flush
    issue(1, 1,  2,  8,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD);
    issue(1, 8,  0, 10,  1,   0,    0,  0, 4'h2, 1, 0, 0,  0,   0, OC_HOLD); // hazard + hold
    issue(1, 8,  0, 10,  1,   0,    0,  0, 4'h2, 0, 0, 0,  0,   1, OC_BUB);
    issue(1, 8,  0, 10,  1,   0,    0,  0, 4'h2, 0, 0, 0,  0,   0, OC_LOAD);
    issue(1, 1,  2,  0,  0,   1,    0,  0, 4'h1, 1, 1, 0,  0,   0, OC_HOLD); // hold beats flush
    issue(1, 1,  2,  0,  0,   1,    0,  0, 4'h1, 0, 1, 0,  0,   0, OC_BUB);
    issue(1, 1,  2,  0,  0,   1,    0,  0, 4'h1, 0, 0, 0,  0,   0, OC_LOAD); // sw
    issue(1, 1,  2,  5,  1,   0,    1,  0, 4'h0, 0, 0, 0,  0,   0, OC_LOAD); // lw $5
    drain();
    // Reset asserted while a load-use stall is pending.
    @(negedge clk);
    #1;
    ID_valid = 1; ID_rs = 5; ID_rt = 2; ID_RW = 6; ID_regwe = 1; ID_memtoreg = 0;
    ID_ramwe = 0; ID_branch = 0; hold = 0; flush = 0; MEM_RW = 0; MEM_memtoreg = 0;
    #1 check("pre_rst_stall", {159'd0, stall}, 160'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ex", {9'd0, act_ex()}, 160'd0);
    check("mid_rst_stall", {159'd0, stall}, 160'd0);
    check("mid_rst_cnt", {128'd0, stall_count}, 160'd0);
    prev_ex = '0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1,  2,  3,  1,   0,    0,  0, 4'h2, 0, 0, 0,  0,   0, OC_LOAD); // add $3
    issue(1, 3,  0, 11,  1,   0,    0,  0, 4'h2, 0, 0, 0,  0,   0, OC_LOAD);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the 5-stage MIPS pipeline. It captures decoded operands and control from the ID stage and presents them as the EX-stage values (`EX_rs`, `EX_rt`, `EX_RW`, write enables) that the forwarding logic compares against MEM/WB destinations. It detects load-use and branch-in-ID hazards that forwarding cannot cover, stalls PC and IF/ID, and inserts bubbles into EX.

## Interface
Parameters:
- `DW`, 32: datapath width (R1, R2, imm, pc).

Ports (the only decided item is clock/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `hold`  in  1  global freeze (memory wait); all state holds.
- `flush`  in  1  squash the instruction entering EX (jump/taken branch).
- `ID_valid`  in  1  ID holds a real instruction.
- `ID_rs`, `ID_rt`, `ID_RW`  in  5 each  source/destination register numbers.
- `ID_regwe`, `ID_ramwe`, `ID_memtoreg`, `ID_branch`  in  1 each  control bits (`memtoreg` = load).
- `ID_aluop`  in  4  ALU operation.
- `ID_R1`, `ID_R2`, `ID_imm`, `ID_pc`  in  DW each  operands, immediate, PC.
- `MEM_RW`  in  5  destination register in MEM.
- `MEM_memtoreg`  in  1  MEM-stage instruction is a load.
- `EX_*`  out  same widths as `ID_*`  registered copies: `EX_valid`, `EX_rs`, `EX_rt`, `EX_RW`, `EX_regwe`, `EX_ramwe`, `EX_memtoreg`, `EX_aluop`, `EX_R1`, `EX_R2`, `EX_imm`, `EX_pc`.
- `stall`  out  1  combinational; 1 = PC and IF/ID must not update.
- `stall_count`  out  32  stall-cycle performance counter.

## Operation
- Hazard (combinational, uses current EX_* and MEM_* values; each term requires `ID_valid`, and the matching register must be nonzero):
  - load-use: `EX_memtoreg && EX_regwe && (EX_RW==ID_rs || EX_RW==ID_rt)`.
  - branch-ALU: `ID_branch && EX_regwe && (EX_RW==ID_rs || EX_RW==ID_rt)`.
  - branch-load: `ID_branch && MEM_memtoreg && (MEM_RW==ID_rs || MEM_RW==ID_rt)`.
- `stall = hazard && !flush && !hold`.
- Priority at each rising edge: `hold` (all EX_* hold, counter holds) > `flush` (bubble) > `stall` (bubble) > normal load of ID_* into EX_*.
- Bubble: every EX_* field is cleared to 0. This includes `EX_valid`, write enables, `EX_RW`/`EX_rs`/`EX_rt` (so the forwarding logic never matches) and the data fields.
- `ID_valid=0` loads normally. Control fields are still gated to 0: `EX_regwe`, `EX_ramwe` and `EX_memtoreg` are ANDed with `ID_valid`.
- Load followed by a dependent branch: the hazard persists across two cycles (EX, then MEM), so 2 bubbles. No extra state is needed beyond the registers.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): all EX_* = 0, `stall_count` = 0; `stall` then evaluates to 0.
- Latency: 1 cycle ID→EX.
- `stall` is valid in the same cycle as the hazard. Upstream samples it at the same edge as this block.
- A reset asserted mid-stall clears EX state immediately. The stalled ID instruction is re-presented by upstream after reset.
- `flush` and `hazard` in the same cycle: a bubble is inserted and `stall=0`, because the ID instruction is squashed upstream.
- `hold` and `flush` in the same cycle: hold wins, and the flush must be re-asserted by its source.

## Configuration
- `ID_EX_PERF_EN`:
  - Defined: `stall_count` increments by 1 on each edge where `stall=1`; it wraps from 0xFFFFFFFF to 0.
  - Undefined: the counter register is not built and `stall_count` is tied to 0.
  - The port exists in both cases.

## Test plan
- Reset: drive `rst_n=0` mid-operation with EX_* nonzero → all EX_* = 0 immediately and `stall=0`; after release, ID `add $3,$1,$2` → EX_RW=3, EX_regwe=1 after 1 edge.
- Load-use: EX=`lw $5` (memtoreg=1, RW=5), ID rs=5 → stall=1 for exactly 1 cycle, EX shows a bubble (EX_valid=0, EX_RW=0), then the ID instruction loads.
- Branch after load: `lw $4` then `beq $4,$0` in ID → stall=1 for 2 consecutive cycles (branch-ALU/load-use, then branch-load), 2 bubbles, then the branch enters EX.
- $0 immunity: EX=`lw $0`, ID rs=0 → stall=0 and no bubble.
- Priority: hazard + flush → stall=0 with a bubble; hazard + hold → stall=0 and EX_* unchanged.
- Counter (with `ID_EX_PERF_EN`): 3 stall cycles → stall_count=3. Preload near wrap and stall 2 cycles from 0xFFFFFFFF → 1. Without the macro → 0 throughout.
